// File: rtl/shiftadd_pkg.sv
// Shared sizing for the shift-add multiplier (control FSM and datapath).
// No logic; constants and width helpers only.
// Both sides import this so the counter width and iteration limit agree.
package shiftadd_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Counter must be able to hold the value WIDTH itself (iterations done).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

  localparam int PROD_W = prod_width(DEFAULT_WIDTH);

endpackage

// File: rtl/shiftadd_datapath_if.sv
// Bundle between shift-add controller/consumer (master) and datapath (slave).
// Purely wiring; no storage or latency.
// product_valid/product_ready form the only backpressured channel.
interface shiftadd_datapath_if
  import shiftadd_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
);

  localparam int PW = prod_width(WIDTH);

  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             load;
  logic             shift;
  logic             add;
  logic             done;
  logic             lsb;
  logic [CNT_W-1:0] count;
  logic [PW-1:0]    product;
  logic             product_valid;
  logic             product_ready;
  logic             overrun;

  modport master (
    output multiplicand, multiplier, load, shift, add, done, product_ready,
    input  lsb, count, product, product_valid, overrun
  );

  modport slave (
    input  multiplicand, multiplier, load, shift, add, done, product_ready,
    output lsb, count, product, product_valid, overrun
  );

endinterface

// File: rtl/shiftadd_result_buffer.sv
// Single-entry holding register for a finished product with valid/ready.
// Latency: valid and data appear the cycle after done_i.
// Backpressure: a done_i while full and not ready overwrites and pulses overrun.
module shiftadd_result_buffer
  import shiftadd_pkg::*;
#(
  parameter int DATA_W = PROD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              overrun_o
);

  logic [DATA_W-1:0] r_q, r_d;
  logic              v_q, v_d;
  logic              ovr_q, ovr_d;

  // Capture on done (always wins), otherwise retire the entry on handshake.
  always_comb begin
    r_d   = r_q;
    v_d   = v_q;
    ovr_d = 1'b0;
    if (done_i) begin
      r_d   = data_i;
      v_d   = 1'b1;
      // Old result still owed to the consumer is being replaced.
      ovr_d = v_q & ~ready_i;
    end else if (v_q && ready_i) begin
      v_d = 1'b0;
    end
  end

  // Result, valid flag and overrun pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= '0;
      v_q   <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      r_q   <= r_d;
      v_q   <= v_d;
      ovr_q <= ovr_d;
    end
  end

  assign data_o    = r_q;
  assign valid_o   = v_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/shiftadd_datapath.sv
// Shift-add multiplier datapath: A/Q/P/CNT registers driven by controller strobes.
// Latency: each strobe lands on the next edge; product valid the cycle after done.
// Backpressure: result buffer absorbs one product; unconsumed overwrite flags overrun.
module shiftadd_datapath
  import shiftadd_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input logic                clk,
  input logic                rst,
  shiftadd_datapath_if.slave dp
);

  localparam int              PW      = prod_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [PW-1:0]    a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [PW-1:0]    p_q, p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Strobe decode with load > shift > add; add is dropped whenever shift is
  // present so a controller holding add into its shift cycle cannot
  // accumulate twice. Shift saturates once all multiplier bits are consumed.
  always_comb begin
    a_d   = a_q;
    q_d   = q_q;
    p_d   = p_q;
    cnt_d = cnt_q;
    if (dp.load) begin
      a_d   = {{WIDTH{1'b0}}, dp.multiplicand};
      q_d   = dp.multiplier;
      p_d   = '0;
      cnt_d = '0;
    end else if (dp.shift) begin
      if (cnt_q < CNT_MAX) begin
        a_d   = a_q << 1;
        q_d   = q_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (dp.add) begin
      p_d = p_q + a_q;
    end
  end

  // Operand, partial-product and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      q_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      q_q   <= q_d;
      p_q   <= p_d;
      cnt_q <= cnt_d;
    end
  end

  // Status back to the controller comes straight from registers.
  assign dp.lsb   = q_q[0];
  assign dp.count = cnt_q;

  // done samples P before any same-cycle add takes effect.
  shiftadd_result_buffer #(
    .DATA_W (PW)
  ) u_result (
    .clk       (clk),
    .rst       (rst),
    .done_i    (dp.done),
    .data_i    (p_q),
    .ready_i   (dp.product_ready),
    .data_o    (dp.product),
    .valid_o   (dp.product_valid),
    .overrun_o (dp.overrun)
  );

endmodule

// File: tb/tb_shiftadd_datapath.sv
module tb_shiftadd_datapath;
  import shiftadd_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = cnt_width(WIDTH);
  localparam int PW    = prod_width(WIDTH);

  localparam int M_NORMAL = 0;
  localparam int M_HOLD   = 1;
  localparam int M_NOADD  = 2;
  localparam int M_EXTRA  = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  shiftadd_datapath_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dp ();

  shiftadd_datapath #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .dp  (dp)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [PW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Emulates the control FSM for one multiply; expected product supplied by caller.
  task automatic run_mult(input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp_p, input int mode, input string tag);
    logic bit_k;
    logic exp_ovr;
    dp.multiplicand = a;
    dp.multiplier   = b;
    dp.load = 1'b1;
    step();
    dp.load = 1'b0;
    chk({tag, " count@load"}, 32'(dp.count), 0);
    for (int k = 0; k < WIDTH; k++) begin
      bit_k = b[k];
      chk({tag, " lsb"}, 32'(dp.lsb), 32'(bit_k));
      if (bit_k && mode != M_NOADD) begin
        dp.add = 1'b1;
        step();
        dp.add = 1'b0;
      end
      dp.shift = 1'b1;
      dp.add   = (mode == M_HOLD);
      step();
      dp.shift = 1'b0;
      dp.add   = 1'b0;
      chk({tag, " count"}, 32'(dp.count), k + 1);
    end
    if (mode == M_EXTRA) begin
      for (int j = 0; j < 2; j++) begin
        dp.shift = 1'b1;
        step();
        dp.shift = 1'b0;
        chk({tag, " count sat"}, 32'(dp.count), WIDTH);
        chk({tag, " lsb sat"}, 32'(dp.lsb), 0);
      end
    end
    exp_ovr = (exp_q.size() != 0) && !dp.product_ready;
    if (exp_ovr) void'(exp_q.pop_back());
    exp_q.push_back(exp_p);
    dp.done = 1'b1;
    step();
    dp.done = 1'b0;
    chk({tag, " valid after done"}, 32'(dp.product_valid), 1);
    chk({tag, " overrun"}, 32'(dp.overrun), 32'(exp_ovr));
  endtask

  // Monitor: every accepted product is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && dp.product_valid && dp.product_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL product unexpected: got %0d, expected no result", dp.product);
      end else begin
        logic [PW-1:0] e;
        e = exp_q.pop_front();
        if (dp.product !== e) begin
          n_fail++;
          $display("FAIL product: got %0d, expected %0d", dp.product, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    dp.multiplicand  = '0;
    dp.multiplier    = '0;
    dp.load          = 1'b0;
    dp.shift         = 1'b0;
    dp.add           = 1'b0;
    dp.done          = 1'b0;
    dp.product_ready = 1'b1;
    #12;
    chk("reset lsb", 32'(dp.lsb), 0);
    chk("reset count", 32'(dp.count), 0);
    chk("reset product", 32'(dp.product), 0);
    chk("reset valid", 32'(dp.product_valid), 0);
    chk("reset overrun", 32'(dp.overrun), 0);
    rst = 1'b0;
    step();

    run_mult(4'd3,  4'd5,  8'd15,  M_NORMAL, "3x5");
    run_mult(4'd15, 4'd15, 8'd225, M_NORMAL, "15x15");
    run_mult(4'd0,  4'd9,  8'd0,   M_NOADD,  "0x9");
    run_mult(4'd9,  4'd0,  8'd0,   M_NORMAL, "9x0");
    run_mult(4'd3,  4'd5,  8'd15,  M_HOLD,   "3x5 hold add");
    run_mult(4'd3,  4'd5,  8'd15,  M_EXTRA,  "3x5 extra shift");
    step();

    // Consumer stalled: second result overwrites the first.
    dp.product_ready = 1'b0;
    run_mult(4'd3, 4'd5, 8'd15, M_NORMAL, "stall 3x5");
    step();
    chk("stall product held", 32'(dp.product), 15);
    chk("stall valid held", 32'(dp.product_valid), 1);
    run_mult(4'd2, 4'd7, 8'd14, M_NORMAL, "stall 2x7");
    step();
    chk("overrun one cycle", 32'(dp.overrun), 0);
    chk("valid while stalled", 32'(dp.product_valid), 1);
    chk("overwritten product", 32'(dp.product), 14);
    dp.product_ready = 1'b1;
    step();
    chk("valid drops after ready", 32'(dp.product_valid), 0);

    // Reset in the middle of 15x15, after the second shift.
    dp.multiplicand = 4'd15;
    dp.multiplier   = 4'd15;
    dp.load = 1'b1;  step(); dp.load = 1'b0;
    dp.add = 1'b1;   step(); dp.add = 1'b0;
    dp.shift = 1'b1; step(); dp.shift = 1'b0;
    dp.add = 1'b1;   step(); dp.add = 1'b0;
    dp.shift = 1'b1; step(); dp.shift = 1'b0;
    chk("pre-reset count", 32'(dp.count), 2);
    rst = 1'b1;
    #1;
    chk("mid reset lsb", 32'(dp.lsb), 0);
    chk("mid reset count", 32'(dp.count), 0);
    chk("mid reset product", 32'(dp.product), 0);
    chk("mid reset valid", 32'(dp.product_valid), 0);
    chk("mid reset overrun", 32'(dp.overrun), 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    run_mult(4'd2, 4'd3, 8'd6, M_NORMAL, "2x3 after reset");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    chk("scoreboard drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
